exp_1x1_ker_write_cont: RTL and testbench

//  Loads expand-1x1 kernel words from the upstream kernel stream into the expand-1x1 kernel RAM.

---
 rtl/exp_1x1_ker_write_cont_if.sv | 23 ++
 rtl/exp_1x1_ker_write_cont.sv | 196 +++++++++++++++++++
 tb/tb_exp_1x1_ker_write_cont.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/exp_1x1_ker_write_cont_if.sv
// Kernel stream handshake bundle between the kernel DMA/stream and the
// expand-1x1 kernel write controller.
interface exp_1x1_ker_write_cont_if #(
   parameter int DATA_W = 64
);
   logic [DATA_W-1:0] ker_data_i;
   logic              ker_valid_i;
   logic              ker_ready_o;

   // stream source side (DMA / bench)
   modport master (
      output ker_data_i,
      output ker_valid_i,
      input  ker_ready_o
   );

   // stream sink side (write controller)
   modport slave (
      input  ker_data_i,
      input  ker_valid_i,
      output ker_ready_o
   );
endinterface

// File: rtl/exp_1x1_ker_write_cont.sv
// Expand-1x1 kernel write controller.
// Streams kernel words into the expand-1x1 kernel RAM at linear addresses and
// publishes how many complete depth layers have landed, so the read
// controller never reads a partially written layer.
// Optional feature macro: EXP1_KER_WR_CHKSUM_EN adds exp_1x1_ker_chksum_o,
// a running XOR of every word written in the current layer-set load.
module exp_1x1_ker_write_cont #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 12
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic                  exp_1x1_en_i,
   input  logic [6:0]            one_exp1_ker_addr_limit_i,
   input  logic [5:0]            exp1_ker_depth_i,
   exp_1x1_ker_write_cont_if.slave ker_if,
   output logic                  exp_1x1_ram_wr_en_o,
   output logic [ADDR_W-1:0]     exp_1x1_ram_wr_addr_o,
   output logic [DATA_W-1:0]     exp_1x1_ram_wr_data_o,
   output logic [6:0]            exp_1x1_layer_ready_no_o,
   output logic                  exp_1x1_ker_wr_done_o,
   output logic                  exp_1x1_cfg_err_o
`ifdef EXP1_KER_WR_CHKSUM_EN
   ,
   output logic [DATA_W-1:0]     exp_1x1_ker_chksum_o
`endif
);

   // RAM capacity in words, expressed in the 13-bit product domain
   localparam logic [12:0] CAP = 13'(2 ** ADDR_W);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [6:0]          limit_q, limit_d;
   logic [5:0]          depth_q, depth_d;
   logic [6:0]          word_cnt_q, word_cnt_d;
   logic [6:0]          layer_cnt_q, layer_cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0]   wr_data_q, wr_data_d;
   logic                layer_pend_q, layer_pend_d;
   logic [6:0]          layer_rdy_q, layer_rdy_d;
   logic                cfg_err_q, cfg_err_d;
`ifdef EXP1_KER_WR_CHKSUM_EN
   logic [DATA_W-1:0]   chk_q, chk_d;
`endif

   logic                ker_ready;
   logic                xfer;
   logic                last_in_layer;
   logic                last_layer;
   logic [12:0]         cfg_prod;
   logic                cfg_bad;

   // handshake: never accept while a new layer-set load is being started
   always_comb begin
      ker_ready     = (state_q == ST_LOAD) && !start_i;
      xfer          = ker_ready && ker_if.ker_valid_i;
      last_in_layer = (word_cnt_q == (limit_q - 7'd1));
      last_layer    = (layer_cnt_q == {1'b0, depth_q});
      cfg_prod      = {6'd0, one_exp1_ker_addr_limit_i} * ({7'd0, exp1_ker_depth_i} + 13'd1);
      cfg_bad       = (one_exp1_ker_addr_limit_i == 7'd0) || (cfg_prod > CAP);
   end

   // next-state and datapath update; start_i overrides whatever the FSM was doing
   always_comb begin
      state_d      = state_q;
      limit_d      = limit_q;
      depth_d      = depth_q;
      word_cnt_d   = word_cnt_q;
      layer_cnt_d  = layer_cnt_q;
      addr_d       = addr_q;
      wr_en_d      = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      layer_pend_d = 1'b0;
      layer_rdy_d  = layer_pend_q ? (layer_rdy_q + 7'd1) : layer_rdy_q;
      cfg_err_d    = cfg_err_q;
`ifdef EXP1_KER_WR_CHKSUM_EN
      chk_d        = chk_q;
`endif

      unique case (state_q)
         ST_IDLE: begin
            state_d = ST_IDLE;
         end
         ST_LOAD: begin
            if (xfer) begin
               wr_en_d   = 1'b1;
               wr_addr_d = addr_q;
               wr_data_d = ker_if.ker_data_i;
               addr_d    = addr_q + ADDR_W'(1);
`ifdef EXP1_KER_WR_CHKSUM_EN
               // folded in at accept so the sum is final alongside the last write
               chk_d     = chk_q ^ ker_if.ker_data_i;
`endif
               if (last_in_layer) begin
                  word_cnt_d   = 7'd0;
                  layer_cnt_d  = layer_cnt_q + 7'd1;
                  // published one cycle after the write strobe, once the word is in RAM
                  layer_pend_d = 1'b1;
                  if (last_layer) begin
                     state_d = ST_DONE;
                  end
               end else begin
                  word_cnt_d = word_cnt_q + 7'd1;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (start_i) begin
         limit_d      = one_exp1_ker_addr_limit_i;
         depth_d      = exp1_ker_depth_i;
         word_cnt_d   = 7'd0;
         layer_cnt_d  = 7'd0;
         addr_d       = '0;
         layer_pend_d = 1'b0;
         layer_rdy_d  = 7'd0;
         cfg_err_d    = exp_1x1_en_i && cfg_bad;
         state_d      = (exp_1x1_en_i && !cfg_bad) ? ST_LOAD : ST_DONE;
`ifdef EXP1_KER_WR_CHKSUM_EN
         chk_d        = '0;
`endif
      end
   end

   // FSM state register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // counters, RAM write port and status registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         limit_q      <= '0;
         depth_q      <= '0;
         word_cnt_q   <= '0;
         layer_cnt_q  <= '0;
         addr_q       <= '0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         layer_pend_q <= 1'b0;
         layer_rdy_q  <= '0;
         cfg_err_q    <= 1'b0;
`ifdef EXP1_KER_WR_CHKSUM_EN
         chk_q        <= '0;
`endif
      end else begin
         limit_q      <= limit_d;
         depth_q      <= depth_d;
         word_cnt_q   <= word_cnt_d;
         layer_cnt_q  <= layer_cnt_d;
         addr_q       <= addr_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         layer_pend_q <= layer_pend_d;
         layer_rdy_q  <= layer_rdy_d;
         cfg_err_q    <= cfg_err_d;
`ifdef EXP1_KER_WR_CHKSUM_EN
         chk_q        <= chk_d;
`endif
      end
   end

   assign ker_if.ker_ready_o       = ker_ready;
   assign exp_1x1_ram_wr_en_o      = wr_en_q;
   assign exp_1x1_ram_wr_addr_o    = wr_addr_q;
   assign exp_1x1_ram_wr_data_o    = wr_data_q;
   assign exp_1x1_layer_ready_no_o = layer_rdy_q;
   assign exp_1x1_ker_wr_done_o    = (state_q == ST_DONE);
   assign exp_1x1_cfg_err_o        = cfg_err_q;
`ifdef EXP1_KER_WR_CHKSUM_EN
   assign exp_1x1_ker_chksum_o     = chk_q;
`endif

endmodule

// File: tb/tb_exp_1x1_ker_write_cont.sv
// Directed bench for exp_1x1_ker_write_cont with a write scoreboard.
// Build with EXP1_KER_WR_CHKSUM_EN defined to also cover the checksum output.
module tb_exp_1x1_ker_write_cont;

   logic        clk;
   logic        rst;
   logic        start;
   logic        en;
   logic [6:0]  lim;
   logic [5:0]  dep;
   logic        wr_en;
   logic [11:0] wr_addr;
   logic [63:0] wr_data;
   logic [6:0]  layer_no;
   logic        done;
   logic        cfg_err;
`ifdef EXP1_KER_WR_CHKSUM_EN
   logic [63:0] chksum;
`endif

   exp_1x1_ker_write_cont_if #(.DATA_W(64)) ker_if ();

   exp_1x1_ker_write_cont #(.DATA_W(64), .ADDR_W(12)) dut (
      .clk_i                     (clk),
      .rst_i                     (rst),
      .start_i                   (start),
      .exp_1x1_en_i              (en),
      .one_exp1_ker_addr_limit_i (lim),
      .exp1_ker_depth_i          (dep),
      .ker_if                    (ker_if),
      .exp_1x1_ram_wr_en_o       (wr_en),
      .exp_1x1_ram_wr_addr_o     (wr_addr),
      .exp_1x1_ram_wr_data_o     (wr_data),
      .exp_1x1_layer_ready_no_o  (layer_no),
      .exp_1x1_ker_wr_done_o     (done),
      .exp_1x1_cfg_err_o         (cfg_err)
`ifdef EXP1_KER_WR_CHKSUM_EN
      ,
      .exp_1x1_ker_chksum_o      (chksum)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_pass = 0;
   int unsigned n_total = 0;
   int unsigned n_wr = 0;
   logic [75:0] sb[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // scoreboard: every RAM write must match the oldest expected accept
   always @(negedge clk) begin
      if (wr_en === 1'b1) begin
         n_wr++;
         if (sb.size() == 0) begin
            chk("wr_unexpected", 64'(wr_en), 64'd0);
         end else begin
            logic [75:0] e;
            e = sb.pop_front();
            chk("wr_addr", 64'(wr_addr), 64'(e[75:64]));
            chk("wr_data", wr_data, e[63:0]);
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
      start = 1'b0;
      ker_if.ker_valid_i = 1'b0;
   endtask

   task automatic do_start(input logic e, input logic [6:0] l, input logic [5:0] d);
      tick;
      start = 1'b1;
      en    = e;
      lim   = l;
      dep   = d;
   endtask

   task automatic drive_word(input logic [11:0] a);
      logic [63:0] w;
      w = {$urandom, $urandom};
      ker_if.ker_valid_i = 1'b1;
      ker_if.ker_data_i  = w;
      sb.push_back({a, w});
   endtask

   initial begin
      int unsigned wr0;
      int unsigned acc;
      int unsigned dcnt;
      logic [63:0] x;

      rst = 1'b1; start = 1'b0; en = 1'b0; lim = '0; dep = '0;
      ker_if.ker_valid_i = 1'b0; ker_if.ker_data_i = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 64'(ker_if.ker_ready_o), 64'd0);
      chk("rst_wr_en", 64'(wr_en), 64'd0);
      chk("rst_layer", 64'(layer_no), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_err", 64'(cfg_err), 64'd0);
      rst = 1'b0;

      // 1: limit 2, depth 2, back-to-back
      do_start(1'b1, 7'd2, 6'd2);
      wr0 = n_wr;
      for (int t = 0; t < 9; t++) begin
         tick;
         if (t < 6) drive_word(12'(t));
         @(negedge clk);
         chk("t1_ready", 64'(ker_if.ker_ready_o), 64'(t < 6));
         chk("t1_layer", 64'(layer_no), 64'((t >= 3) + (t >= 5) + (t >= 7)));
         chk("t1_done", 64'(done), 64'(t == 6));
         chk("t1_err", 64'(cfg_err), 64'd0);
      end
      chk("t1_nwr", 64'(n_wr - wr0), 64'd6);
      chk("t1_sb_empty", 64'(sb.size()), 64'd0);

      // 2: same config, valid toggling
      do_start(1'b1, 7'd2, 6'd2);
      wr0 = n_wr; acc = 0; dcnt = 0;
      for (int t = 0; t < 16; t++) begin
         tick;
         if (acc < 6 && (t % 2) == 0) begin
            drive_word(12'(acc));
            acc++;
         end
         @(negedge clk);
         if (done === 1'b1) dcnt++;
      end
      chk("t2_nwr", 64'(n_wr - wr0), 64'd6);
      chk("t2_layer", 64'(layer_no), 64'd3);
      chk("t2_done_cnt", 64'(dcnt), 64'd1);
      chk("t2_sb_empty", 64'(sb.size()), 64'd0);

      // 3: expand disabled
      do_start(1'b0, 7'd2, 6'd2);
      wr0 = n_wr;
      for (int t = 0; t < 4; t++) begin
         tick;
         ker_if.ker_valid_i = 1'b1;
         @(negedge clk);
         chk("t3_done", 64'(done), 64'(t == 0));
         chk("t3_ready", 64'(ker_if.ker_ready_o), 64'd0);
         chk("t3_err", 64'(cfg_err), 64'd0);
         chk("t3_layer", 64'(layer_no), 64'd0);
      end
      chk("t3_nwr", 64'(n_wr - wr0), 64'd0);

      // 4a: full RAM, 64 x 64 words
      do_start(1'b1, 7'd64, 6'd63);
      wr0 = n_wr;
      for (int i = 0; i < 4096; i++) begin
         tick;
         drive_word(12'(i));
      end
      tick;
      @(negedge clk);
      chk("t4_done", 64'(done), 64'd1);
      chk("t4_ready", 64'(ker_if.ker_ready_o), 64'd0);
      chk("t4_err", 64'(cfg_err), 64'd0);
      tick;
      @(negedge clk);
      chk("t4_layer", 64'(layer_no), 64'd64);
      chk("t4_nwr", 64'(n_wr - wr0), 64'd4096);
      chk("t4_sb_empty", 64'(sb.size()), 64'd0);

      // 4b: one word over capacity
      do_start(1'b1, 7'd65, 6'd63);
      wr0 = n_wr;
      tick;
      ker_if.ker_valid_i = 1'b1;
      @(negedge clk);
      chk("t4b_err", 64'(cfg_err), 64'd1);
      chk("t4b_done", 64'(done), 64'd1);
      chk("t4b_ready", 64'(ker_if.ker_ready_o), 64'd0);
      chk("t4b_layer", 64'(layer_no), 64'd0);
      tick;
      @(negedge clk);
      chk("t4b_err_sticky", 64'(cfg_err), 64'd1);
      chk("t4b_done_off", 64'(done), 64'd0);
      chk("t4b_nwr", 64'(n_wr - wr0), 64'd0);

      // 4c: zero words per layer
      do_start(1'b1, 7'd0, 6'd0);
      tick;
      @(negedge clk);
      chk("t4c_err", 64'(cfg_err), 64'd1);
      chk("t4c_done", 64'(done), 64'd1);

      // 5: restart after 3 of 6 words; word in the start cycle is dropped
      do_start(1'b1, 7'd2, 6'd2);
      for (int t = 0; t < 3; t++) begin
         tick;
         drive_word(12'(t));
      end
      do_start(1'b1, 7'd2, 6'd2);
      ker_if.ker_valid_i = 1'b1;
      ker_if.ker_data_i  = 64'hDEAD_BEEF_0BAD_F00D;
      @(negedge clk);
      chk("t5_ready_at_start", 64'(ker_if.ker_ready_o), 64'd0);
      chk("t5_layer_before", 64'(layer_no), 64'd1);
      tick;
      drive_word(12'd0);
      @(negedge clk);
      chk("t5_layer_cleared", 64'(layer_no), 64'd0);
      chk("t5_err_cleared", 64'(cfg_err), 64'd0);
      tick;
      @(negedge clk);
      tick;
      @(negedge clk);
      chk("t5_layer_hold", 64'(layer_no), 64'd0);
      chk("t5_sb_empty", 64'(sb.size()), 64'd0);

      // 6: asynchronous reset mid-load
      do_start(1'b1, 7'd2, 6'd2);
      for (int t = 0; t < 3; t++) begin
         tick;
         drive_word(12'(t));
      end
      tick;
      #2;
      rst = 1'b1;
      #1;
      chk("t6_ready", 64'(ker_if.ker_ready_o), 64'd0);
      chk("t6_wr_en", 64'(wr_en), 64'd0);
      chk("t6_addr", 64'(wr_addr), 64'd0);
      chk("t6_data", wr_data, 64'd0);
      chk("t6_layer", 64'(layer_no), 64'd0);
      chk("t6_done", 64'(done), 64'd0);
      sb.delete();
      @(negedge clk);
      rst = 1'b0;

`ifdef EXP1_KER_WR_CHKSUM_EN
      // checksum over one 4-word layer
      do_start(1'b1, 7'd4, 6'd0);
      x = '0;
      for (int t = 0; t < 4; t++) begin
         tick;
         drive_word(12'(t));
         x = x ^ ker_if.ker_data_i;
      end
      tick;
      @(negedge clk);
      chk("chk_done", 64'(done), 64'd1);
      chk("chksum", chksum, x);
      do_start(1'b1, 7'd4, 6'd0);
      tick;
      @(negedge clk);
      chk("chksum_clear", chksum, 64'd0);
`else
      x = '0;
`endif

      chk("final_sb_empty", 64'(sb.size()), 64'(x != x));
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
